// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM states, mode constants and counter sizing shared by the serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cnt_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple-carry adder; also exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] c;

    assign c[0] = cin_i;

    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        assign sum_o[g] = a_i[g] ^ b_i[g] ^ c[g];
        assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
    end

    assign cout_o = c[DIGIT];
    assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, LSB digit first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, sum_q, sum_d;
    logic             c_q, c_d, co_q, co_d, ov_q, ov_d;
    logic [DIGIT-1:0] ds;
    logic             dco, dcm, last;
    logic [WIDTH-1:0] p_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .cin_i (c_q),
        .sum_o (ds),
        .cout_o(dco),
        .cmsb_o(dcm)
    );

    // New digit enters at the MSB end; after STEPS shifts the word is fully aligned.
    assign p_next = WIDTH'({ds, p_q} >> DIGIT);
    assign last   = cnt_q == CW'(STEPS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            RUN: begin
                state_d = last ? DONE : RUN;
                cnt_d   = cnt_q + CW'(1);
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                c_d     = dco;
                p_d     = p_next;
                sum_d   = last ? p_next : sum_q;
                co_d    = last ? dco : co_q;
                ov_d    = last ? dcm ^ dco : ov_q;
            end
            default: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    cnt_d = '0;
                    a_d   = a;
                    b_d   = (sub == MODE_SUB) ? ~b : b;
                    c_d   = (sub == MODE_ADD) ? carry_in : 1'b1;
                    p_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign sum       = sum_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of DIGIT=1 and DIGIT=4 adders against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, carry_in = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy8, done8, co8, ov8, busy4, done4, co4, ov4;
    logic [7:0] sum8, sum4;
    int         n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry_out, sum}; carry_out for sub means no borrow.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
        int r, sr;
        r  = s ? 256 + int'(x) - int'(y) : int'(x) + int'(y) + int'(ci);
        sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y)) + int'(ci);
        return {(sr > 127 || sr < -128), r >= 256, r[7:0]};
    endfunction

    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s, input bit inject);
        logic [9:0] e;
        logic [7:0] prev8, prev4;
        int         d8 = 0, d4 = 0, nb8 = 0, nb4 = 0;
        bit         held = 1;
        e = model(x, y, ci, s);
        @(posedge clk);
        #1 a = x; b = y; carry_in = ci; sub = s; start = 1'b1;
        prev8 = sum8;
        prev4 = sum4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (inject && i == 2) begin
                start = 1'b1; a = ~x; b = x; sub = ~s; carry_in = ~ci;
            end
            if (inject && i == 3) start = 1'b0;
            if (busy8) nb8++;
            if (busy4) nb4++;
            if ((busy8 && sum8 !== prev8) || (busy4 && sum4 !== prev4)) held = 0;
            if (done8 && d8 == 0) begin
                d8 = i;
                chk("sum8", sum8, e[7:0]);
                chk("cout8", co8, e[8]);
                chk("ovf8", ov8, e[9]);
            end
            if (done4 && d4 == 0) begin
                d4 = i;
                chk("sum4", sum4, e[7:0]);
                chk("cout4", co4, e[8]);
                chk("ovf4", ov4, e[9]);
            end
            if (d8 != 0 && d4 != 0) break;
        end
        chk("lat8", d8, 9);
        chk("lat4", d4, 3);
        chk("busy8_cycles", nb8, 8);
        chk("busy4_cycles", nb4, 2);
        chk("hold", held, 1);
    endtask

    initial begin
        logic [9:0] e;
        int         w, nd;
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ovf", ov8, 0);
        @(negedge clk) rst_n = 1'b1;
        op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        op(8'h3C, 8'hC4, 1'b1, 1'b0, 0);
        op(8'h12, 8'h34, 1'b0, 1'b0, 1);
        // Back-to-back: start raised during the DONE cycle of the DIGIT=1 instance.
        op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        a = 8'h40; b = 8'h30; sub = 1'b1; carry_in = 1'b0; start = 1'b1;
        e = model(8'h40, 8'h30, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_busy", busy8, 1);
        chk("b2b_done_low", done8, 0);
        start = 1'b0;
        for (w = 0; w < 12 && !done8; w++) @(negedge clk);
        chk("b2b_seen", done8, 1);
        chk("b2b_sum", sum8, e[7:0]);
        chk("b2b_cout", co8, e[8]);
        repeat (40) op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        // Asynchronous reset in the middle of RUN.
        @(posedge clk);
        #1 a = 8'h6B; b = 8'h2D; sub = 1'b0; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy8, 0);
        chk("mid_done", done8, 0);
        chk("mid_sum", sum8, 0);
        chk("mid_cout", co8, 0);
        chk("mid_ovf", ov8, 0);
        chk("mid_done4", done4, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("no_done", nd, 0);
        op(8'h01, 8'h01, 1'b0, 1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
